// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: memory request/response, redirect and decode handshake.
// The master modport is the fetch queue; the slave modport is its environment.
interface fetch_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc_plus4;
    logic          out_ready;

    modport master (
        output req_valid, req_addr, out_valid, out_instr, out_pc_plus4,
        input  req_ready, rsp_valid, rsp_data, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_instr, out_pc_plus4,
        output req_ready, rsp_valid, rsp_data, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential requests to a fixed-order memory,
// a circular prefetch buffer of {instr, pc+4}, and redirect-driven flush.
module fetch_queue #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input logic           clka,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW:0]   CAP      = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [AW-1:0] PC_STEP  = AW'(3'd4);

    logic [AW-1:0] fetch_pc_r;
    logic [AW-1:0] rsp_pc_r;
    logic [DW-1:0] instr_r [DEPTH];
    logic [AW-1:0] pc4_r   [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] drop_r;

    logic          req_valid_s;
    logic          req_fire_s;
    logic          rsp_ok_s;
    logic          push_s;
    logic          pop_s;
    logic [CW:0]   occupancy_s;
    logic [CW-1:0] inflight_nxt_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    // Request is held off while in reset, while redirecting, or when every slot is claimed.
    assign occupancy_s = {1'b0, count_r} + {1'b0, inflight_r};
    assign req_valid_s = rst && !bus.redirect && (occupancy_s < CAP);
    assign req_fire_s  = req_valid_s && bus.req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok_s    = bus.rsp_valid && (inflight_r != CNT_ZERO);
    assign push_s      = rsp_ok_s && (drop_r == CNT_ZERO) && !bus.redirect;
    assign pop_s       = (count_r != CNT_ZERO) && bus.out_ready;

    assign bus.req_valid    = req_valid_s;
    assign bus.req_addr     = fetch_pc_r;
    assign bus.out_valid    = (count_r != CNT_ZERO);
    assign bus.out_instr    = instr_r[rd_ptr_r];
    assign bus.out_pc_plus4 = pc4_r[rd_ptr_r];

    // Outstanding-request count after this cycle's issue and response.
    always_comb begin
        inflight_nxt_s = inflight_r;
        if (req_fire_s && !rsp_ok_s) begin
            inflight_nxt_s = inflight_r + CNT_ONE;
        end else if (!req_fire_s && rsp_ok_s) begin
            inflight_nxt_s = inflight_r - CNT_ONE;
        end else begin
            inflight_nxt_s = inflight_r;
        end
    end

    // PCs, pointers and counters; redirect overrides every other update.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            inflight_r <= CNT_ZERO;
            drop_r     <= CNT_ZERO;
        end else if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc;
            rsp_pc_r   <= bus.redirect_pc;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            inflight_r <= inflight_nxt_s;
            drop_r     <= inflight_nxt_s;
        end else begin
            inflight_r <= inflight_nxt_s;
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (rsp_ok_s && (drop_r != CNT_ZERO)) begin
                drop_r <= drop_r - CNT_ONE;
            end
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
                rsp_pc_r <= rsp_pc_r + PC_STEP;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // Buffer storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_r[i] <= {DW{1'b0}};
                pc4_r[i]   <= {AW{1'b0}};
            end
        end else if (push_s) begin
            instr_r[wr_ptr_r] <= bus.rsp_data;
            pc4_r[wr_ptr_r]   <= rsp_pc_r + PC_STEP;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue with an in-order variable-latency memory model.
module tb_fetch_queue;
    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clka;
    logic rst;

    fetch_queue_if #(.AW(AW), .DW(DW)) bus ();

    fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected stream of {instr, pc+4} for live requests.
    logic [31:0] sb_instr[$];
    logic [31:0] sb_pc4[$];
    logic [31:0] exp_pc = RESET_PC;
    int outstanding = 0;
    int stale = 0;
    int buffered = 0;
    int pops = 0;

    // Memory model: accepted addresses with the cycle their response is due.
    logic [31:0] mem_addr[$];
    int mem_due[$];
    int cyc = 0;
    int lat = 1;
    bit pending_release = 1'b0;
    bit inject = 1'b0;

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs at the falling edge, then log any accepted request.
    task automatic step(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
        @(negedge clka);
        if (pending_release) begin
            rst = 1'b1;
            pending_release = 1'b0;
        end
        cyc++;
        bus.req_ready   = rdy;
        bus.out_ready   = ordy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        if (rst && mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = instr_of(mem_addr.pop_front());
            mem_due.delete(0);
        end else if (inject) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = 32'hBAD0_BAD0;
            inject = 1'b0;
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = 32'h0000_0000;
        end
        #1;
        if (rst && bus.req_valid && bus.req_ready) begin
            mem_addr.push_back(bus.req_addr);
            mem_due.push_back(cyc + lat);
        end
    endtask

    task automatic async_reset();
        @(negedge clka);
        bus.req_ready = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect  = 1'b0;
        bus.rsp_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_out_instr", bus.out_instr, 32'd0);
        chk("async_rst_out_pc4", bus.out_pc_plus4, 32'd0);
        chk("async_rst_req_valid", 32'(bus.req_valid), 32'd0);
        mem_addr.delete();
        mem_due.delete();
    endtask

    // Monitor: samples between edges, updates the model and compares every popped entry.
    initial begin : monitor
        int occ;
        forever begin
            @(negedge clka);
            #2;
            if (!rst) begin
                chk("reset_req_valid", 32'(bus.req_valid), 32'd0);
                chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
                sb_instr.delete();
                sb_pc4.delete();
                exp_pc = RESET_PC;
                outstanding = 0;
                stale = 0;
                buffered = 0;
            end else begin
                occ = sb_instr.size() + stale;
                chk("out_valid", 32'(bus.out_valid), 32'(buffered != 0));
                if (bus.out_valid && bus.out_ready) begin
                    pops++;
                    if (sb_instr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop: got instr %h pc4 %h expected none at %0t",
                                 bus.out_instr, bus.out_pc_plus4, $time);
                    end else begin
                        chk("out_instr", bus.out_instr, sb_instr.pop_front());
                        chk("out_pc_plus4", bus.out_pc_plus4, sb_pc4.pop_front());
                    end
                    if (buffered > 0) buffered--;
                end
                if (bus.redirect) begin
                    chk("req_valid_redirect", 32'(bus.req_valid), 32'd0);
                end else begin
                    chk("req_valid_room", 32'(bus.req_valid), 32'(occ < DEPTH));
                end
                if (bus.req_valid) chk("req_addr", bus.req_addr, exp_pc);
                if (bus.req_valid && bus.req_ready) begin
                    sb_instr.push_back(instr_of(exp_pc));
                    sb_pc4.push_back(exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    outstanding++;
                end
                if (bus.rsp_valid && outstanding > 0) begin
                    outstanding--;
                    if (stale > 0) stale--;
                    else buffered++;
                end
                if (bus.redirect) begin
                    sb_instr.delete();
                    sb_pc4.delete();
                    buffered = 0;
                    stale = outstanding;
                    exp_pc = bus.redirect_pc;
                end
            end
        end
    end

    initial begin : driver
        bit seen;
        int p0;
        rst = 1'b0;
        bus.req_ready = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data = 32'h0;
        #1;
        chk("por_out_instr", bus.out_instr, 32'd0);
        chk("por_out_pc4", bus.out_pc_plus4, 32'd0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Streaming with 1-cycle memory: first output two cycles after release.
        lat = 1;
        pending_release = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (k == 0) chk("first_req_addr", bus.req_addr, RESET_PC);
            if (!seen && bus.out_valid) begin
                seen = 1'b1;
                chk("first_out_cycle", 32'(k), 32'd2);
                chk("first_out_pc4", bus.out_pc_plus4, RESET_PC + 32'd4);
            end
        end
        chk("first_out_seen", 32'(seen), 32'd1);

        // Decode stalled: buffer fills to DEPTH, then drains in order.
        for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_req_valid", 32'(bus.req_valid), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // 2-cycle memory streams at full rate; 3-cycle memory at four per five cycles.
        lat = 2;
        for (int k = 0; k < 15; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        p0 = pops;
        for (int k = 0; k < 30; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rate_lat2", 32'(pops - p0), 32'd30);
        lat = 3;
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        p0 = pops;
        for (int k = 0; k < 30; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rate_lat3", 32'(pops - p0), 32'd24);

        // Redirect with requests in flight: stale responses must be dropped.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_out_valid_n1", 32'(bus.out_valid), 32'd0);
        chk("redir_req_addr_n1", bus.req_addr, 32'h0000_0100);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (!seen && bus.out_valid) begin
                seen = 1'b1;
                chk("redir_first_pc4", bus.out_pc_plus4, 32'h0000_0104);
                chk("redir_first_instr", bus.out_instr, instr_of(32'h0000_0100));
            end
        end
        chk("redir_output_seen", 32'(seen), 32'd1);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("redir2_req_valid", 32'(bus.req_valid), 32'd1);
        chk("redir2_req_addr", bus.req_addr, 32'h0000_0200);

        // Random traffic, latencies and redirects (including address wrap).
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) lat = $urandom_range(1, 4);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 4,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC));
        end

        // Asynchronous reset with a full buffer.
        lat = 1;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        async_reset();
        for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        pending_release = 1'b1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_reset_req_valid", 32'(bus.req_valid), 32'd1);
        chk("post_reset_req_addr", bus.req_addr, RESET_PC);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Spurious response with nothing outstanding must be ignored.
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        inject = (mem_addr.size() == 0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 32'h0);

        @(negedge clka);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
